// File: rtl/atom_iosys_multi_pkg.sv
// Shared decode codes and reset constants for the multi-console Atom I/O block.
package atom_io_pkg;

  typedef enum logic [1:0] {
    REG_PIO   = 2'd0,
    REG_EXT   = 2'd1,
    REG_VIA   = 2'd2,
    REG_VGAIO = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    PIO_A   = 2'd0,
    PIO_B   = 2'd1,
    PIO_C   = 2'd2,
    PIO_CTL = 2'd3
  } pio_off_e;

  localparam logic [3:0] IO_PAGE    = 4'hB;
  localparam logic [7:0] UNMAP_MASK = 8'hF1;
  localparam logic [7:0] RST_COL0   = 8'h03;
  localparam logic [7:0] RST_COLN   = 8'hFF;
  localparam logic [3:0] RST_KBROW  = 4'hF;

  // Unmapped locations float back the high address byte through the bus mask.
  function automatic logic [7:0] unmapped_rd(input logic [7:0] page);
    return page & UNMAP_MASK;
  endfunction

endpackage

// File: rtl/atom_vsync_edge.sv
// Synchronises the asynchronous vsync_n and flags the first cycle of flyback.
module atom_vsync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic vsync_n_i,
  output logic vs_sync_o,
  output logic frame_tick_o
);

  logic s1_q, s2_q, s3_q;

  // Two-stage synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= vsync_n_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign vs_sync_o    = s2_q;
  assign frame_tick_o = ~s2_q & s3_q;

endmodule

// File: rtl/atom_iosys_multi.sv
// Multi-console Atom #BXXX I/O block: per-console PIO and palette, tone divider,
// and display shadows reloaded only at flyback start.
module atom_iosys_multi
  import atom_io_pkg::*;
#(
  parameter int NCON     = 4,
  parameter int NCOL     = 4,
  parameter int CBITS    = 6,
  parameter int TONE_DIV = 5208,
  localparam int CW      = (NCON > 1) ? $clog2(NCON) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [18:0]           address,
  input  logic [7:0]            Din,
  output logic [7:0]            Dout,
  input  logic                  WE,
  output logic                  IO_sel,
  input  logic [7:0]            key_in,
  input  logic                  rept_n,
  input  logic                  cas_in,
  input  logic                  vsync_n,
  input  logic [CW-1:0]         visible,
  input  logic [CW-1:0]         active,
  output logic [3:0]            key_row,
  output logic [3:0]            gmod,
  output logic [NCOL*CBITS-1:0] colors,
  output logic                  tape_out,
  output logic                  speaker,
  output logic                  frame_tick
);

  localparam int IW = $clog2(NCOL);
  localparam int TW = $clog2(TONE_DIV);
  localparam logic [CBITS-1:0] RC0 = RST_COL0[CBITS-1:0];
  localparam logic [CBITS-1:0] RCN = RST_COLN[CBITS-1:0];
  localparam logic [TW-1:0]    DIV_LAST = TW'(TONE_DIV - 1);

  logic [3:0]       kbrow_q [NCON];
  logic [3:0]       gmode_q [NCON];
  logic [3:0]       portc_q [NCON];
  logic [CBITS-1:0] pal_q   [NCON][NCOL];

  logic [TW-1:0]         div_q;
  logic                  tone_q;
  logic [3:0]            gmod_q;
  logic [NCOL*CBITS-1:0] colors_q;

  logic          io_sel_s, con_ok_s, wr_s, vs_sync_s, frame_tick_s, unused_s;
  logic [CW-1:0] con_s, vis_s, act_s;
  logic [IW-1:0] pidx_s;
  logic [7:0]    rd_s;
  region_e       region_s;
  pio_off_e      poff_s;

  // Out-of-range console numbers fall back to console 0 for display/keyboard use.
  function automatic logic [CW-1:0] clamp_con(input logic [CW-1:0] c);
    if (int'(c) < NCON) return c;
    else return {CW{1'b0}};
  endfunction

  assign io_sel_s = (address[15:12] == IO_PAGE);
  assign con_s    = address[16 +: CW];
  assign con_ok_s = (int'(con_s) < NCON);
  assign pidx_s   = address[IW-1:0];
  assign region_s = region_e'(address[11:10]);
  assign poff_s   = pio_off_e'(address[1:0]);
  assign wr_s     = WE & io_sel_s & con_ok_s;
  assign vis_s    = clamp_con(visible);
  assign act_s    = clamp_con(active);
  assign unused_s = ^address;

  atom_vsync_edge u_vsync (
    .clk_i        (clk),
    .reset_i      (reset),
    .vsync_n_i    (vsync_n),
    .vs_sync_o    (vs_sync_s),
    .frame_tick_o (frame_tick_s)
  );

  // CPU-visible per-console registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCON; i++) begin
        kbrow_q[i] <= RST_KBROW;
        gmode_q[i] <= 4'h0;
        portc_q[i] <= 4'h0;
        for (int j = 0; j < NCOL; j++) begin
          pal_q[i][j] <= (j == 0) ? RC0 : RCN;
        end
      end
    end else if (wr_s) begin
      case (region_s)
        REG_PIO: begin
          case (poff_s)
            PIO_A: begin
              kbrow_q[con_s] <= Din[3:0];
              gmode_q[con_s] <= Din[7:4];
            end
            PIO_C:   portc_q[con_s] <= Din[3:0];
            default: ;
          endcase
        end
        REG_VGAIO: pal_q[con_s][pidx_s] <= Din[CBITS-1:0];
        default:   ;
      endcase
    end
  end

  // Tone half-period divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= {TW{1'b0}};
      tone_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q  <= {TW{1'b0}};
      tone_q <= ~tone_q;
    end else begin
      div_q  <= div_q + TW'(1);
    end
  end

  // Display shadows; a write landing in the load cycle is seen next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      gmod_q <= 4'h0;
      for (int j = 0; j < NCOL; j++) begin
        colors_q[j*CBITS +: CBITS] <= (j == 0) ? RC0 : RCN;
      end
    end else if (frame_tick_s) begin
      gmod_q <= gmode_q[vis_s];
      for (int j = 0; j < NCOL; j++) begin
        colors_q[j*CBITS +: CBITS] <= ((j == 0) && (visible == active)) ?
                                      {CBITS{1'b0}} : pal_q[vis_s][j];
      end
    end
  end

  // CPU read mux.
  always_comb begin
    rd_s = unmapped_rd(address[15:8]);
    if (io_sel_s) begin
      case (region_s)
        REG_PIO: begin
          if (!con_ok_s) begin
            rd_s = 8'hFF;
          end else begin
            case (poff_s)
              PIO_A:   rd_s = {gmode_q[con_s], kbrow_q[con_s]};
              PIO_B:   rd_s = (con_s == active) ? key_in : 8'hFF;
              PIO_C:   rd_s = {vs_sync_s, rept_n, cas_in, tone_q, portc_q[con_s]};
              default: rd_s = unmapped_rd(address[15:8]);
            endcase
          end
        end
        REG_VGAIO: begin
          if (!con_ok_s) begin
            rd_s = 8'hFF;
          end else begin
            rd_s = 8'h00;
            rd_s[CBITS-1:0] = pal_q[con_s][pidx_s];
          end
        end
        default: rd_s = unmapped_rd(address[15:8]);
      endcase
    end else begin
      rd_s = unmapped_rd(address[15:8]);
    end
  end

  assign Dout       = rd_s;
  assign IO_sel     = io_sel_s;
  assign key_row    = kbrow_q[act_s];
  assign gmod       = gmod_q;
  assign colors     = colors_q;
  assign tape_out   = portc_q[act_s][0] ^ (portc_q[act_s][1] & tone_q);
  assign speaker    = portc_q[act_s][2];
  assign frame_tick = frame_tick_s;

endmodule

// File: tb/tb_atom_iosys_multi.sv
// Scoreboard bench for atom_iosys_multi with four consoles, 16-entry palettes, fast tone.
module tb_atom_iosys_multi;
  localparam int NCON = 4, NCOL = 16, CBITS = 6, TONE_DIV = 4, CW = 2;

  logic clk = 1'b0, reset = 1'b1, WE = 1'b0, IO_sel;
  logic [18:0] address = 19'h0;
  logic [7:0] Din = 8'h00, Dout, key_in = 8'hFF;
  logic rept_n = 1'b1, cas_in = 1'b0, vsync_n = 1'b1;
  logic [CW-1:0] visible = 2'd0, active = 2'd0;
  logic [3:0] key_row, gmod;
  logic [NCOL*CBITS-1:0] colors;
  logic tape_out, speaker, frame_tick;

  int errors = 0, checks = 0, tick_cnt = 0;
  logic [127:0] exp_q [$];
  logic [127:0] e;
  logic [7:0] d;

  atom_iosys_multi #(.NCON(NCON), .NCOL(NCOL), .CBITS(CBITS), .TONE_DIV(TONE_DIV)) dut (
    .clk(clk), .reset(reset), .address(address), .Din(Din), .Dout(Dout), .WE(WE),
    .IO_sel(IO_sel), .key_in(key_in), .rept_n(rept_n), .cas_in(cas_in), .vsync_n(vsync_n),
    .visible(visible), .active(active), .key_row(key_row), .gmod(gmod), .colors(colors),
    .tape_out(tape_out), .speaker(speaker), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  // Reference tone phase: clock edges since reset was last released.
  always @(posedge clk) begin
    if (reset) tick_cnt <= 0;
    else tick_cnt <= tick_cnt + 1;
  end

  function automatic logic tone_model();
    return ((tick_cnt / TONE_DIV) % 2) == 1;
  endfunction

  function automatic logic [18:0] A(input int con, input logic [15:0] off);
    logic [1:0] c;
    c = con[1:0];
    return {1'b0, c, off};
  endfunction

  function automatic logic [CBITS-1:0] ent(input int i);
    return colors[i*CBITS +: CBITS];
  endfunction

  task automatic wr(input logic [18:0] a, input logic [7:0] v);
    @(negedge clk); address = a; Din = v; WE = 1'b1;
    @(negedge clk); WE = 1'b0;
  endtask

  task automatic rd(input logic [18:0] a, output logic [7:0] v);
    @(negedge clk); address = a; #1; v = Dout;
  endtask

  task automatic flyback();
    @(negedge clk); vsync_n = 1'b0;
    repeat (3) @(negedge clk);
    vsync_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    exp_q.push_back(128'(8'h0F)); rd(A(0, 16'hB000), d);
    checks++; e = exp_q.pop_front();
    if (128'(d) !== e) begin errors++; $display("FAIL reset_pio0 got=%h exp=%h", d, e[7:0]); end
    exp_q.push_back(128'(4'h0));
    checks++; e = exp_q.pop_front();
    if (128'(gmod) !== e) begin errors++; $display("FAIL reset_gmod got=%h exp=%h", gmod, e[3:0]); end
    exp_q.push_back(128'(6'h03));
    checks++; e = exp_q.pop_front();
    if (128'(ent(0)) !== e) begin errors++; $display("FAIL reset_col0 got=%h exp=%h", ent(0), e[5:0]); end
    exp_q.push_back(128'(6'h3F));
    checks++; e = exp_q.pop_front();
    if (128'(ent(5)) !== e) begin errors++; $display("FAIL reset_col5 got=%h exp=%h", ent(5), e[5:0]); end
    exp_q.push_back(128'({1'b0, 1'b0, 1'b0}));
    checks++; e = exp_q.pop_front();
    if (128'({tape_out, speaker, frame_tick}) !== e)
      begin errors++; $display("FAIL reset_outs got=%b%b%b exp=000", tape_out, speaker, frame_tick); end
    exp_q.push_back(128'({1'b0, 8'hA0})); rd(19'h0A055, d);
    checks++; e = exp_q.pop_front();
    if (128'({IO_sel, d}) !== e) begin errors++; $display("FAIL unsel_read got=%b/%h exp=0/a0", IO_sel, d); end
  endtask

  task automatic test_pio();
    wr(A(2, 16'hB000), 8'hA3);
    wr(A(2, 16'hB001), 8'h55);
    exp_q.push_back(128'(8'hA3)); rd(A(2, 16'hB000), d);
    checks++; e = exp_q.pop_front();
    if (128'(d) !== e) begin errors++; $display("FAIL pio_readback got=%h exp=%h", d, e[7:0]); end
    exp_q.push_back(128'(4'hF)); #1;
    checks++; e = exp_q.pop_front();
    if (128'(key_row) !== e) begin errors++; $display("FAIL key_row_act0 got=%h exp=%h", key_row, e[3:0]); end
    active = 2'd2; exp_q.push_back(128'(4'h3)); #1;
    checks++; e = exp_q.pop_front();
    if (128'(key_row) !== e) begin errors++; $display("FAIL key_row_act2 got=%h exp=%h", key_row, e[3:0]); end
    exp_q.push_back(128'(8'hB0)); rd(A(1, 16'hB403), d);
    checks++; e = exp_q.pop_front();
    if (128'(d) !== e) begin errors++; $display("FAIL ext_read got=%h exp=%h", d, e[7:0]); end
    visible = 2'd2;
    @(negedge clk); vsync_n = 1'b0;
    @(posedge clk); #1; exp_q.push_back(128'({1'b0, 4'h0}));
    checks++; e = exp_q.pop_front();
    if (128'({frame_tick, gmod}) !== e) begin errors++; $display("FAIL vs_edge1 got=%b/%h exp=0/0", frame_tick, gmod); end
    @(posedge clk); #1; exp_q.push_back(128'({1'b1, 4'h0}));
    checks++; e = exp_q.pop_front();
    if (128'({frame_tick, gmod}) !== e) begin errors++; $display("FAIL vs_edge2 got=%b/%h exp=1/0", frame_tick, gmod); end
    @(posedge clk); #1; exp_q.push_back(128'({1'b0, 4'hA}));
    checks++; e = exp_q.pop_front();
    if (128'({frame_tick, gmod}) !== e) begin errors++; $display("FAIL vs_edge3 got=%b/%h exp=0/a", frame_tick, gmod); end
    @(negedge clk); vsync_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_keys();
    exp_q.push_back(128'(8'hFF)); rd(A(0, 16'hB001), d);
    checks++; e = exp_q.pop_front();
    if (128'(d) !== e) begin errors++; $display("FAIL key_other got=%h exp=%h", d, e[7:0]); end
    key_in = 8'h7E;
    exp_q.push_back(128'(8'h7E)); rd(A(2, 16'hB001), d);
    checks++; e = exp_q.pop_front();
    if (128'(d) !== e) begin errors++; $display("FAIL key_active got=%h exp=%h", d, e[7:0]); end
    rept_n = 1'b0; cas_in = 1'b1;
    @(negedge clk); address = A(2, 16'hB002);
    exp_q.push_back(128'({1'b1, 1'b0, 1'b1, tone_model(), 4'h0})); #1;
    checks++; e = exp_q.pop_front();
    if (128'(Dout) !== e) begin errors++; $display("FAIL portc_read got=%h exp=%h", Dout, e[7:0]); end
    rept_n = 1'b1; cas_in = 1'b0;
  endtask

  task automatic test_palette();
    active = 2'd0;
    wr(A(1, 16'hBC0B), 8'hD5);
    exp_q.push_back(128'(8'h15)); rd(A(1, 16'hBC0B), d);
    checks++; e = exp_q.pop_front();
    if (128'(d) !== e) begin errors++; $display("FAIL pal_readback got=%h exp=%h", d, e[7:0]); end
    visible = 2'd1;
    flyback();
    exp_q.push_back(128'({6'h15, 6'h03}));
    checks++; e = exp_q.pop_front();
    if (128'({ent(11), ent(0)}) !== e) begin errors++; $display("FAIL pal_load got=%h/%h exp=15/03", ent(11), ent(0)); end
    active = 2'd1; exp_q.push_back(128'(6'h03)); #1;
    checks++; e = exp_q.pop_front();
    if (128'(ent(0)) !== e) begin errors++; $display("FAIL pal_no_reload got=%h exp=%h", ent(0), e[5:0]); end
    flyback();
    exp_q.push_back(128'({6'h15, 6'h00}));
    checks++; e = exp_q.pop_front();
    if (128'({ent(11), ent(0)}) !== e) begin errors++; $display("FAIL pal_act_vis got=%h/%h exp=15/00", ent(11), ent(0)); end
  endtask

  task automatic test_tone();
    active = 2'd3;
    wr(A(3, 16'hB002), 8'h03);
    @(negedge clk); address = A(3, 16'hB002);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      exp_q.push_back(128'({tone_model(), ~tone_model()}));
      checks++; e = exp_q.pop_front();
      if (128'({Dout[4], tape_out}) !== e)
        begin errors++; $display("FAIL tone_%0d got=%b/%b exp=%b/%b", k, Dout[4], tape_out, e[1], e[0]); end
    end
    wr(A(3, 16'hB002), 8'h04);
    exp_q.push_back(128'({1'b1, 1'b0})); #1;
    checks++; e = exp_q.pop_front();
    if (128'({speaker, tape_out}) !== e) begin errors++; $display("FAIL speaker got=%b/%b exp=1/0", speaker, tape_out); end
  endtask

  task automatic test_back_to_back();
    active = 2'd0; visible = 2'd1;
    @(negedge clk); vsync_n = 1'b0;
    @(negedge clk); @(negedge clk);
    exp_q.push_back(128'(1'b1));
    checks++; e = exp_q.pop_front();
    if (128'(frame_tick) !== e) begin errors++; $display("FAIL collide_tick got=%b exp=1", frame_tick); end
    address = A(1, 16'hBC02); Din = 8'h2A; WE = 1'b1;
    @(negedge clk); WE = 1'b0;
    exp_q.push_back(128'(6'h3F));
    checks++; e = exp_q.pop_front();
    if (128'(ent(2)) !== e) begin errors++; $display("FAIL collide_old got=%h exp=%h", ent(2), e[5:0]); end
    vsync_n = 1'b1; repeat (3) @(negedge clk);
    exp_q.push_back(128'(8'h2A)); rd(A(1, 16'hBC02), d);
    checks++; e = exp_q.pop_front();
    if (128'(d) !== e) begin errors++; $display("FAIL collide_reg got=%h exp=%h", d, e[7:0]); end
    flyback();
    exp_q.push_back(128'(6'h2A));
    checks++; e = exp_q.pop_front();
    if (128'(ent(2)) !== e) begin errors++; $display("FAIL collide_new got=%h exp=%h", ent(2), e[5:0]); end
  endtask

  task automatic test_reset_midframe();
    logic ft_seen;
    visible = 2'd2;
    flyback();
    exp_q.push_back(128'(4'hA));
    checks++; e = exp_q.pop_front();
    if (128'(gmod) !== e) begin errors++; $display("FAIL pre_reset_gmod got=%h exp=%h", gmod, e[3:0]); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(128'(4'h0));
    checks++; e = exp_q.pop_front();
    if (128'(gmod) !== e) begin errors++; $display("FAIL midreset_gmod got=%h exp=%h", gmod, e[3:0]); end
    @(negedge clk); reset = 1'b0;
    ft_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; ft_seen = ft_seen | frame_tick;
    end
    exp_q.push_back(128'(1'b0));
    checks++; e = exp_q.pop_front();
    if (128'(ft_seen) !== e) begin errors++; $display("FAIL midreset_tick got=%b exp=0", ft_seen); end
    exp_q.push_back(128'(8'h0F)); rd(A(2, 16'hB000), d);
    checks++; e = exp_q.pop_front();
    if (128'(d) !== e) begin errors++; $display("FAIL midreset_pio got=%h exp=%h", d, e[7:0]); end
  endtask

  initial begin
    test_reset();
    test_pio();
    test_keys();
    test_palette();
    test_tone();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
